branch_resolve: RTL and testbench

- Decode-stage branch resolver for the 5-stage DLX pipeline. It consumes BEQZ, BNEZ and JR instructions in ID.
- It zero-tests the rs1 operand and computes the target.
- It stalls ID/IF while rs1 is still being produced by an instruction in EX or MEM.
- One cycle after capture it issues a registered redirect and flush to IF/ID.

---
 rtl/dlx_branch_pkg.sv | 23 ++
 rtl/branch_hazard_detect.sv | 27 ++
 rtl/branch_resolve.sv | 166 ++++++++++++++++
 tb/tb_branch_resolve.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_branch_pkg.sv
// Shared definitions for the decode-stage branch resolver.
//   br_op_t  : branch-class opcode encodings seen on br_op
//   state_t  : resolver FSM states
//   STALL_EX / STALL_MEM : stall lengths for a producer in EX / MEM
package dlx_branch_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQZ = 2'b01,
    BR_BNEZ = 2'b10,
    BR_JR   = 2'b11
  } br_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [1:0] STALL_EX  = 2'd2;
  localparam logic [1:0] STALL_MEM = 2'd1;

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational RAW hazard check for the branch source register.
// Ports:
//   rs1_addr            : register the branch reads
//   ex_wr_en / ex_rd    : destination write of the instruction in EX
//   mem_wr_en / mem_rd  : destination write of the instruction in MEM
//   hz_ex / hz_mem      : rs1 is still being produced in EX / MEM
// A value in WB is not a hazard: the register file writes before it reads.
module branch_hazard_detect #(
  parameter int REG_BITS = 5
) (
  input  logic [0:REG_BITS-1] rs1_addr,
  input  logic                ex_wr_en,
  input  logic [0:REG_BITS-1] ex_rd,
  input  logic                mem_wr_en,
  input  logic [0:REG_BITS-1] mem_rd,
  output logic                hz_ex,
  output logic                hz_mem
);

  // r0 is hard-wired to zero, so a write to it can never be a hazard.
  logic rs1_nz;

  assign rs1_nz = |rs1_addr;
  assign hz_ex  = ex_wr_en  & (ex_rd  == rs1_addr) & rs1_nz;
  assign hz_mem = mem_wr_en & (mem_rd == rs1_addr) & rs1_nz;

endmodule

// File: rtl/branch_resolve.sv
// Decode-stage branch resolver for the 5-stage DLX pipeline.
// Handles BEQZ, BNEZ and JR in ID: waits out RAW hazards on rs1, then
// evaluates the branch and, one cycle after capture, issues a registered
// redirect plus a flush of the wrong-path instruction in ID.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   valid_in, br_op   : branch-class instruction in ID and its opcode
//   rs1_addr/rs1_data : source register and its register-file value
//   pc_plus4, imm     : branch PC + 4 and sign-extended offset
//   ex_* / mem_*      : destination writes of the EX and MEM instructions
//   stall_out         : hold PC and IF/ID, bubble into EX
//   redirect_valid    : one-cycle pulse, load redirect_pc into PC
//   redirect_pc       : branch / jump target
//   flush_id          : one-cycle pulse, squash the instruction in ID
// Optional: define BRANCH_STATS_EN to add saturating 32-bit counters
//   stat_taken, stat_not_taken and stat_stall_cycles.
module branch_resolve
  import dlx_branch_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  input  logic [0:1]          br_op,
  input  logic [0:REG_BITS-1] rs1_addr,
  input  logic [0:WIDTH-1]    rs1_data,
  input  logic [0:WIDTH-1]    pc_plus4,
  input  logic [0:WIDTH-1]    imm,
  input  logic                ex_wr_en,
  input  logic [0:REG_BITS-1] ex_rd,
  input  logic                mem_wr_en,
  input  logic [0:REG_BITS-1] mem_rd,
`ifdef BRANCH_STATS_EN
  output logic [0:31]         stat_taken,
  output logic [0:31]         stat_not_taken,
  output logic [0:31]         stat_stall_cycles,
`endif
  output logic                stall_out,
  output logic                redirect_valid,
  output logic [0:WIDTH-1]    redirect_pc,
  output logic                flush_id
);

  state_t                    state_p0, state_nxt;
  logic [1:0]                cnt_p0, cnt_nxt;
  logic                      hz_ex, hz_mem;
  logic                      br_valid, accept, capture;
  logic                      rs1_zero, take_nxt;
  logic signed [WIDTH-1:0]   pc4_s, imm_s, rel_tgt_s;
  logic        [WIDTH-1:0]   tgt_nxt;
  logic                      vld_p0, flush_p0;
  logic        [WIDTH-1:0]   tgt_p0;

  branch_hazard_detect #(
    .REG_BITS (REG_BITS)
  ) u_hazard (
    .rs1_addr  (rs1_addr),
    .ex_wr_en  (ex_wr_en),
    .ex_rd     (ex_rd),
    .mem_wr_en (mem_wr_en),
    .mem_rd    (mem_rd),
    .hz_ex     (hz_ex),
    .hz_mem    (hz_mem)
  );

  assign br_valid = valid_in & (br_op != BR_NONE);
  // In RESOLVE a taken branch is flushing ID, so whatever sits there is ignored;
  // a not-taken resolve frees ID for a back-to-back branch.
  assign accept   = (state_p0 == IDLE) | ((state_p0 == RESOLVE) & ~vld_p0);

  // Next-state logic
  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    capture   = 1'b0;
    case (state_p0)
      IDLE, RESOLVE: begin
        state_nxt = IDLE;
        if (accept & br_valid) begin
          if (hz_ex) begin
            state_nxt = STALL;
            cnt_nxt   = STALL_EX;
          end else if (hz_mem) begin
            state_nxt = STALL;
            cnt_nxt   = STALL_MEM;
          end else begin
            state_nxt = RESOLVE;
            capture   = 1'b1;
          end
        end
      end
      STALL: begin
        cnt_nxt = cnt_p0 - 2'd1;
        if (cnt_p0 <= 2'd1) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 2'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    stall_out = (state_p0 == STALL);
  end

  // Branch evaluation on the operands being captured; the result is
  // registered so every RESOLVE output comes straight from a flop.
  assign rs1_zero  = ~|rs1_data;
  assign pc4_s     = pc_plus4;
  assign imm_s     = imm;
  assign rel_tgt_s = pc4_s + imm_s;
  assign take_nxt  = capture & (((br_op == BR_BEQZ) &  rs1_zero) |
                                ((br_op == BR_BNEZ) & ~rs1_zero) |
                                 (br_op == BR_JR));
  assign tgt_nxt   = (br_op == BR_JR) ? WIDTH'(rs1_data) : WIDTH'(rel_tgt_s);

  // State register and capture -> RESOLVE boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0 <= IDLE;
      cnt_p0   <= 2'd0;
      vld_p0   <= 1'b0;
      flush_p0 <= 1'b0;
      tgt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      vld_p0   <= take_nxt;
      flush_p0 <= take_nxt;
      if (take_nxt) tgt_p0 <= tgt_nxt;
    end
  end

  assign redirect_valid = vld_p0;
  assign flush_id       = flush_p0;
  assign redirect_pc    = tgt_p0;

`ifdef BRANCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] taken_p0, not_taken_p0, stall_cyc_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_p0     <= '0;
      not_taken_p0 <= '0;
      stall_cyc_p0 <= '0;
    end else begin
      if ((state_p0 == RESOLVE) &  vld_p0) taken_p0     <= sat_inc(taken_p0);
      if ((state_p0 == RESOLVE) & ~vld_p0) not_taken_p0 <= sat_inc(not_taken_p0);
      if (stall_out)                       stall_cyc_p0 <= sat_inc(stall_cyc_p0);
    end
  end

  assign stat_taken        = taken_p0;
  assign stat_not_taken    = not_taken_p0;
  assign stat_stall_cycles = stall_cyc_p0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [0:1]  br_op;
  logic [0:4]  rs1_addr;
  logic [0:31] rs1_data;
  logic [0:31] pc_plus4;
  logic [0:31] imm;
  logic        ex_wr_en;
  logic [0:4]  ex_rd;
  logic        mem_wr_en;
  logic [0:4]  mem_rd;
  logic        stall_out;
  logic        redirect_valid;
  logic [0:31] redirect_pc;
  logic        flush_id;
`ifdef BRANCH_STATS_EN
  logic [0:31] stat_taken, stat_not_taken, stat_stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve #(.WIDTH(32), .REG_BITS(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .br_op          (br_op),
    .rs1_addr       (rs1_addr),
    .rs1_data       (rs1_data),
    .pc_plus4       (pc_plus4),
    .imm            (imm),
    .ex_wr_en       (ex_wr_en),
    .ex_rd          (ex_rd),
    .mem_wr_en      (mem_wr_en),
    .mem_rd         (mem_rd),
`ifdef BRANCH_STATS_EN
    .stat_taken        (stat_taken),
    .stat_not_taken    (stat_not_taken),
    .stat_stall_cycles (stat_stall_cycles),
`endif
    .stall_out      (stall_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_id       (flush_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and outputs are handled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    br_op     = 2'b00;
    rs1_addr  = '0;
    rs1_data  = '0;
    pc_plus4  = '0;
    imm       = '0;
    ex_wr_en  = 1'b0;
    ex_rd     = '0;
    mem_wr_en = 1'b0;
    mem_rd    = '0;
  endtask

  task automatic branch(input logic [1:0] op, input logic [4:0] ra,
                        input logic [31:0] d, input logic [31:0] p4,
                        input logic [31:0] im);
    valid_in = 1'b1;
    br_op    = op;
    rs1_addr = ra;
    rs1_data = d;
    pc_plus4 = p4;
    imm      = im;
  endtask

  task automatic expect_out(input string tag, input logic st, input logic rv,
                            input logic fl, input logic [31:0] pc);
    check({tag, ".stall"},    32'(stall_out),      32'(st));
    check({tag, ".redirect"}, 32'(redirect_valid), 32'(rv));
    check({tag, ".flush"},    32'(flush_id),       32'(fl));
    check({tag, ".pc"},       redirect_pc,         pc);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    expect_out("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    step();

    // Taken BEQZ
    branch(2'b01, 5'd1, 32'h0, 32'h100, 32'h20);
    check("beqz_t.pre_stall", 32'(stall_out), 32'(0));
    step();
    idle();
    expect_out("beqz_t", 1'b0, 1'b1, 1'b1, 32'h120);
    step();
    expect_out("beqz_t.after", 1'b0, 1'b0, 1'b0, 32'h120);

    // Not-taken BNEZ: redirect_pc keeps its last value
    branch(2'b10, 5'd2, 32'h0, 32'h200, 32'h40);
    step();
    idle();
    expect_out("bnez_nt", 1'b0, 1'b0, 1'b0, 32'h120);
    step();

    // Negative offset
    branch(2'b10, 5'd2, 32'h5, 32'h100, 32'hFFFF_FFF0);
    step();
    idle();
    expect_out("neg_off", 1'b0, 1'b1, 1'b1, 32'hF0);
    step();

    // Jump register
    branch(2'b11, 5'd3, 32'hDEAD_0000, 32'h200, 32'h4);
    step();
    idle();
    expect_out("jr", 1'b0, 1'b1, 1'b1, 32'hDEAD_0000);
    step();

    // br_op = 00 is not a branch, even with a hazard present
    branch(2'b00, 5'd7, 32'h0, 32'h100, 32'h8);
    ex_wr_en = 1'b1;
    ex_rd    = 5'd7;
    step();
    idle();
    expect_out("op_none", 1'b0, 1'b0, 1'b0, 32'hDEAD_0000);
    step();

    // EX hazard: two stall cycles, then resolve with the refreshed rs1
    branch(2'b01, 5'd7, 32'h55, 32'h300, 32'h10);
    ex_wr_en = 1'b1;
    ex_rd    = 5'd7;
    step();
    ex_wr_en  = 1'b0;
    mem_wr_en = 1'b1;
    mem_rd    = 5'd7;
    check("ex_hz.stall1", 32'(stall_out), 32'(1));
    check("ex_hz.rv1",    32'(redirect_valid), 32'(0));
    step();
    mem_wr_en = 1'b0;
    check("ex_hz.stall2", 32'(stall_out), 32'(1));
    step();
    rs1_data = 32'h0;
    check("ex_hz.stall3", 32'(stall_out), 32'(0));
    step();
    idle();
    expect_out("ex_hz.res", 1'b0, 1'b1, 1'b1, 32'h310);
    step();

    // MEM hazard: one stall cycle
    branch(2'b10, 5'd3, 32'h1, 32'h400, 32'h8);
    mem_wr_en = 1'b1;
    mem_rd    = 5'd3;
    step();
    mem_wr_en = 1'b0;
    check("mem_hz.stall1", 32'(stall_out), 32'(1));
    step();
    check("mem_hz.stall2", 32'(stall_out), 32'(0));
    step();
    idle();
    expect_out("mem_hz.res", 1'b0, 1'b1, 1'b1, 32'h408);
    step();

    // r0 is never a hazard
    branch(2'b11, 5'd0, 32'h40, 32'h500, 32'h4);
    ex_wr_en = 1'b1;
    ex_rd    = 5'd0;
    step();
    idle();
    expect_out("r0", 1'b0, 1'b1, 1'b1, 32'h40);
    step();

    // Reset in the middle of a stall aborts the branch
    branch(2'b11, 5'd9, 32'h900, 32'h0, 32'h0);
    ex_wr_en = 1'b1;
    ex_rd    = 5'd9;
    step();
    check("rst_mid.stall", 32'(stall_out), 32'(1));
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_out("rst_mid", 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check("rst_mid.no_rv", 32'(redirect_valid), 32'(0));
    step();
    check("rst_mid.no_rv2", 32'(redirect_valid), 32'(0));

    // Back-to-back: not-taken BEQZ then taken BNEZ captured in RESOLVE
    branch(2'b01, 5'd4, 32'h5, 32'h500, 32'h10);
    step();
    check("b2b.rv_first", 32'(redirect_valid), 32'(0));
    branch(2'b10, 5'd4, 32'h5, 32'h600, 32'h20);
    step();
    idle();
    expect_out("b2b.second", 1'b0, 1'b1, 1'b1, 32'h620);
    step();
    check("b2b.after", 32'(redirect_valid), 32'(0));

    // Taken branch: the instruction in ID during RESOLVE is ignored
    branch(2'b11, 5'd5, 32'h700, 32'h0, 32'h0);
    step();
    branch(2'b01, 5'd6, 32'h0, 32'h800, 32'h4);
    expect_out("b2b_t.first", 1'b0, 1'b1, 1'b1, 32'h700);
    step();
    idle();
    expect_out("b2b_t.ignored", 1'b0, 1'b0, 1'b0, 32'h700);
    step();
    expect_out("b2b_t.ignored2", 1'b0, 1'b0, 1'b0, 32'h700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
